// File: rtl/iob2axi_bridge_pkg.sv
// Shared AXI4 encodings and FSM state constants for the IOb-to-AXI4 bridge.
package iob2axi_bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B       = 3'd2;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_WADDR = 3'd1;
  localparam state_t ST_WRESP = 3'd2;
  localparam state_t ST_RADDR = 3'd3;
  localparam state_t ST_RDATA = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

endpackage

// File: rtl/iob2axi_bridge.sv
// IOb native memory port to single-beat AXI4 master, one transaction in flight.
module iob2axi_bridge
  import iob2axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32,
  parameter int AXI_ID = 0,
  parameter int ID_W   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iob_valid,
  input  logic [ADDR_W-1:0]   iob_addr,
  input  logic [DATA_W-1:0]   iob_wdata,
  input  logic [DATA_W/8-1:0] iob_wstrb,
  output logic [DATA_W-1:0]   iob_rdata,
  output logic                iob_ready,
  output logic                iob_err,
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awlock,
  output logic [3:0]          m_axi_awcache,
  output logic [2:0]          m_axi_awprot,
  output logic [3:0]          m_axi_awqos,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arlock,
  output logic [3:0]          m_axi_arcache,
  output logic [2:0]          m_axi_arprot,
  output logic [3:0]          m_axi_arqos,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [ID_W-1:0]     m_axi_rid,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                aw_done;
  logic                w_done;
  logic                err_q;
  logic                aw_hs;
  logic                w_hs;

  // Single-beat transactions carry no useful ID/last information back.
  logic unused_inputs;
  assign unused_inputs = ^{m_axi_bid, m_axi_rid, m_axi_rlast, iob_addr[1:0]};

  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid & m_axi_wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iob_valid) begin
            addr_q  <= {iob_addr[ADDR_W-1:2], 2'b00};
            wdata_q <= iob_wdata;
            wstrb_q <= iob_wstrb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= (|iob_wstrb) ? ST_WADDR : ST_RADDR;
          end
        end
        // AW and W complete independently; leave once both have been accepted.
        ST_WADDR: begin
          aw_done <= aw_done | aw_hs;
          w_done  <= w_done | w_hs;
          if ((aw_done | aw_hs) && (w_done | w_hs)) begin
            state <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (m_axi_bvalid) begin
            err_q <= (m_axi_bresp != AXI_RESP_OKAY);
            state <= ST_DONE;
          end
        end
        ST_RADDR: begin
          if (m_axi_arready) begin
            state <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (m_axi_rvalid) begin
            rdata_q <= m_axi_rdata;
            err_q   <= (m_axi_rresp != AXI_RESP_OKAY);
            state   <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs decode straight from state so an async reset drops them at once.
  assign m_axi_awvalid = (state == ST_WADDR) && !aw_done;
  assign m_axi_wvalid  = (state == ST_WADDR) && !w_done;
  assign m_axi_bready  = (state == ST_WRESP);
  assign m_axi_arvalid = (state == ST_RADDR);
  assign m_axi_rready  = (state == ST_RDATA);
  assign iob_ready     = (state == ST_DONE);
  assign iob_err       = (state == ST_DONE) && err_q;
  assign iob_rdata     = rdata_q;

  assign m_axi_awid    = ID_W'(AXI_ID);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = AXI_SIZE_4B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = AXI_CACHE_DEFAULT;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wlast   = 1'b1;

  assign m_axi_arid    = ID_W'(AXI_ID);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = AXI_SIZE_4B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = AXI_CACHE_DEFAULT;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arqos   = 4'd0;

endmodule

// File: tb/tb_iob2axi_bridge.sv
// Scoreboard bench for iob2axi_bridge against a small AXI slave memory model.
module tb_iob2axi_bridge;

  logic        clk, rst;
  logic        iob_valid;
  logic [23:0] iob_addr;
  logic [31:0] iob_wdata;
  logic [3:0]  iob_wstrb;
  logic [31:0] iob_rdata;
  logic        iob_ready, iob_err;
  logic [0:0]  m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic [23:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic        m_axi_awlock, m_axi_arlock;
  logic [3:0]  m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready, m_axi_rlast;

  iob2axi_bridge dut (
    .clk(clk), .rst(rst),
    .iob_valid(iob_valid), .iob_addr(iob_addr), .iob_wdata(iob_wdata), .iob_wstrb(iob_wstrb),
    .iob_rdata(iob_rdata), .iob_ready(iob_ready), .iob_err(iob_err),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   vecs = 0;
  int   errs = 0;
  int   cyc = 0;
  int   t_issue = 0;

  // Slave model configuration and captured traffic
  int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] mem [0:255];
  int          aw_cnt, w_cnt, ar_cnt, b_cnt;
  logic        got_aw, got_w, b_pend;
  logic [23:0] cap_awaddr, cap_araddr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;
  int          aw_hi = 0, w_hi = 0, ar_hi = 0, w_beats = 0, viol = 0;
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;

  assign m_axi_bid     = 1'b0;
  assign m_axi_rid     = 1'b0;
  assign m_axi_rlast   = 1'b1;
  assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_wait);
  assign m_axi_wready  = m_axi_wvalid && (w_cnt >= w_wait);
  assign m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_wait);

  wire        aw_now = m_axi_awvalid && m_axi_awready;
  wire        w_now  = m_axi_wvalid && m_axi_wready;
  wire        ar_now = m_axi_arvalid && m_axi_arready;
  wire [23:0] wr_addr = aw_now ? m_axi_awaddr : cap_awaddr;
  wire [31:0] wr_data = w_now ? m_axi_wdata : cap_wdata;
  wire [3:0]  wr_strb = w_now ? m_axi_wstrb : cap_wstrb;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; b_pend <= 1'b0;
      m_axi_bvalid <= 1'b0; m_axi_rvalid <= 1'b0;
      m_axi_bresp <= 2'b00; m_axi_rresp <= 2'b00; m_axi_rdata <= 32'h0;
      cap_awaddr <= '0; cap_araddr <= '0; cap_wdata <= '0; cap_wstrb <= '0;
    end else begin
      aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_axi_wvalid && !m_axi_wready) ? w_cnt + 1 : 0;
      ar_cnt <= (m_axi_arvalid && !m_axi_arready) ? ar_cnt + 1 : 0;
      if (aw_now) begin got_aw <= 1'b1; cap_awaddr <= m_axi_awaddr; end
      if (w_now) begin got_w <= 1'b1; cap_wdata <= m_axi_wdata; cap_wstrb <= m_axi_wstrb; end
      if ((got_aw || aw_now) && (got_w || w_now)) begin
        got_aw <= 1'b0;
        got_w  <= 1'b0;
        for (int i = 0; i < 4; i++)
          if (wr_strb[i]) mem[wr_addr[9:2]][8*i +: 8] <= wr_data[8*i +: 8];
        m_axi_bresp <= bresp_cfg;
        if (b_wait == 0) m_axi_bvalid <= 1'b1;
        else begin b_pend <= 1'b1; b_cnt <= 1; end
      end
      if (b_pend) begin
        if (b_cnt >= b_wait) begin m_axi_bvalid <= 1'b1; b_pend <= 1'b0; end
        else b_cnt <= b_cnt + 1;
      end
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (ar_now) begin
        cap_araddr   <= m_axi_araddr;
        m_axi_rdata  <= mem[m_axi_araddr[9:2]];
        m_axi_rresp  <= rresp_cfg;
        m_axi_rvalid <= 1'b1;
      end
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
    end
  end

  // Cycle counters and valid-stability watch (valid must not drop before its handshake)
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0; p_wr <= 1'b0; p_arv <= 1'b0; p_arr <= 1'b0;
    end else begin
      if (m_axi_awvalid) aw_hi <= aw_hi + 1;
      if (m_axi_wvalid)  w_hi  <= w_hi + 1;
      if (m_axi_arvalid) ar_hi <= ar_hi + 1;
      if (w_now) w_beats <= w_beats + 1;
      if ((p_awv && !p_awr && !m_axi_awvalid) || (p_wv && !p_wr && !m_axi_wvalid) ||
          (p_arv && !p_arr && !m_axi_arvalid))
        viol <= viol + 1;
      p_awv <= m_axi_awvalid; p_awr <= m_axi_awready;
      p_wv  <= m_axi_wvalid;  p_wr  <= m_axi_wready;
      p_arv <= m_axi_arvalid; p_arr <= m_axi_arready;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop one expectation per completion pulse
  logic prev_ready = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_ready = 1'b0;
    end else begin
      if (prev_ready) check("ready_pulse_width", {31'b0, iob_ready}, 32'h0);
      if (iob_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.rd) begin
            check("araddr", {8'h0, cap_araddr}, {8'h0, e.addr});
            check("iob_rdata", iob_rdata, e.rdata);
          end else begin
            check("awaddr", {8'h0, cap_awaddr}, {8'h0, e.addr});
            check("wdata", cap_wdata, e.wdata);
            check("wstrb", {28'h0, cap_wstrb}, {28'h0, e.wstrb});
          end
          check("iob_err", {31'b0, iob_err}, {31'b0, e.err});
          if (e.lat >= 0) check("latency", cyc - t_issue, e.lat);
        end
      end
      prev_ready = iob_ready;
    end
  end

  task automatic do_req(input logic [23:0] a, input logic [31:0] d, input logic [3:0] s,
                        input exp_t e);
    bit seen;
    @(negedge clk);
    iob_addr  = a;
    iob_wdata = d;
    iob_wstrb = s;
    iob_valid = 1'b1;
    t_issue   = cyc;
    sb.push_back(e);
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (iob_ready) seen = 1;
    end
    if (!seen) check("ready_timeout", 32'h0, 32'h1);
    iob_valid = 1'b0;
  endtask

  function automatic exp_t mk(bit rd, logic [23:0] a, logic [31:0] wd, logic [3:0] ws,
                              logic [31:0] rdv, logic er, int lat);
    exp_t e;
    e.rd = rd; e.addr = a; e.wdata = wd; e.wstrb = ws; e.rdata = rdv; e.err = er; e.lat = lat;
    return e;
  endfunction

  initial begin
    int aw0, w0, ar0, wb0;
    bit seen;
    rst = 1'b1; iob_valid = 1'b0; iob_addr = '0; iob_wdata = '0; iob_wstrb = '0;
    repeat (3) @(negedge clk);
    check("rst_iob_ready", {31'b0, iob_ready}, 32'h0);
    check("rst_iob_err", {31'b0, iob_err}, 32'h0);
    check("rst_iob_rdata", iob_rdata, 32'h0);
    check("rst_valids", {29'b0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 32'h0);
    check("rst_readies", {30'b0, m_axi_bready, m_axi_rready}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait write then read back
    do_req(24'h000104, 32'hDEADBEEF, 4'hF, mk(0, 24'h000104, 32'hDEADBEEF, 4'hF, 0, 0, 3));
    do_req(24'h000104, 32'h0, 4'h0, mk(1, 24'h000104, 0, 0, 32'hDEADBEEF, 0, 3));
    repeat (3) @(negedge clk);
    check("rdata_hold", iob_rdata, 32'hDEADBEEF);

    // W accepted at once, AW stalled three extra cycles
    aw_wait = 3;
    aw0 = aw_hi; w0 = w_hi; wb0 = w_beats;
    do_req(24'h000200, 32'h12345678, 4'hF, mk(0, 24'h000200, 32'h12345678, 4'hF, 0, 0, -1));
    check("awvalid_cycles", aw_hi - aw0, 4);
    check("wvalid_cycles", w_hi - w0, 1);
    check("w_beats", w_beats - wb0, 1);
    check("rdata_kept_on_write", iob_rdata, 32'hDEADBEEF);
    aw_wait = 0;

    // AR stalled, slave error response
    ar_wait = 3; rresp_cfg = 2'b10;
    ar0 = ar_hi;
    do_req(24'h000200, 32'h0, 4'h0, mk(1, 24'h000200, 0, 0, 32'h12345678, 1, -1));
    check("arvalid_cycles", ar_hi - ar0, 4);
    ar_wait = 0; rresp_cfg = 2'b00;

    // Unaligned address with a single byte strobe
    do_req(24'h000107, 32'h0000AA00, 4'h2, mk(0, 24'h000104, 32'h0000AA00, 4'h2, 0, 0, 3));

    // Reset while waiting for B
    b_wait = 6;
    @(negedge clk);
    iob_addr = 24'h000300; iob_wdata = 32'hCAFEF00D; iob_wstrb = 4'hF; iob_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (m_axi_bready) seen = 1;
    end
    check("reached_wresp", {31'b0, seen}, 32'h1);
    rst = 1'b1;
    #1;
    check("rst_mid_valids", {30'b0, m_axi_awvalid, m_axi_wvalid}, 32'h0);
    check("rst_mid_bready", {31'b0, m_axi_bready}, 32'h0);
    check("rst_mid_iob_ready", {31'b0, iob_ready}, 32'h0);
    iob_valid = 1'b0;
    b_wait = 0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_rdata", iob_rdata, 32'h0);
    do_req(24'h000104, 32'h0, 4'h0, mk(1, 24'h000104, 0, 0, 32'hDEADAAEF, 0, 3));

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    check("valid_stability", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/iob2axi_bridge.md
Name: iob2axi_bridge

Overview:
- Converts the system's native IOb memory port (valid/addr/wdata/wstrb/rdata/ready) into single-beat AXI4 master transactions.
- Sits directly upstream of the AXI interconnect slave port, in front of the DDR model / DDR controller.
- Handles one outstanding transaction at a time: a write issues AW+W and waits for B; a read issues AR and waits for R.

Parameters:
ADDR_W, 24, byte address width (matches DDR_ADDR_W)
DATA_W, 32, data width; only 32 supported
AXI_ID, 0, constant value driven on awid/arid
ID_W, 1, AXI ID width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
iob_valid  in  1  request valid; held by master until iob_ready
iob_addr  in  ADDR_W  byte address
iob_wdata  in  DATA_W  write data
iob_wstrb  in  DATA_W/8  byte strobes; nonzero=write, zero=read
iob_rdata  out  DATA_W  read data, valid when iob_ready on a read
iob_ready  out  1  one-cycle completion pulse
iob_err  out  1  pulses with iob_ready when xRESP != OKAY
m_axi_awid/arid  out  ID_W  AXI_ID
m_axi_awaddr/araddr  out  ADDR_W  word-aligned address
m_axi_awlen/arlen  out  8  constant 0
m_axi_awsize/arsize  out  3  constant 2
m_axi_awburst/arburst  out  2  constant 1 (INCR)
m_axi_awlock/arlock  out  1  constant 0
m_axi_awcache/arcache  out  4  constant 4'b0011
m_axi_awprot/arprot  out  3  constant 0
m_axi_awqos/arqos  out  4  constant 0
m_axi_awvalid, m_axi_awready  out/in  1  AW handshake
m_axi_wdata  out  DATA_W  write data
m_axi_wstrb  out  DATA_W/8  write strobes
m_axi_wlast  out  1  constant 1
m_axi_wvalid, m_axi_wready  out/in  1  W handshake
m_axi_bid  in  ID_W  ignored
m_axi_bresp  in  2  write response
m_axi_bvalid, m_axi_bready  in/out  1  B handshake
m_axi_arvalid, m_axi_arready  out/in  1  AR handshake
m_axi_rid  in  ID_W  ignored
m_axi_rdata  in  DATA_W  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  ignored (single beat)
m_axi_rvalid, m_axi_rready  in/out  1  R handshake

Behaviour:
- Reset values: all valid/ready outputs 0, iob_rdata 0, iob_err 0, captured address/data/strobe registers 0, state IDLE. Reset asserted mid-transaction drops all valids on the asserting edge. No recovery handshake toward the slave.
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA, DONE.
- IDLE: on iob_valid, register addr[ADDR_W-1:2]&2'b00, wdata and wstrb. If |wstrb, go to WADDR. Else go to RADDR.
- WADDR:
  - awvalid and wvalid are both asserted the cycle after capture.
  - Each channel deasserts independently on its own handshake, tracked by flags aw_done/w_done.
  - Simultaneous or either-order handshakes are legal.
  - Go to WRESP when both are done, including the case where both complete in the same cycle.
  - awvalid/wvalid are never deasserted before their handshake.
- WRESP: bready=1. On bvalid, latch err=(bresp!=0) and go to DONE.
- RADDR: arvalid=1 until arready, then go to RDATA.
- RDATA: rready=1. On rvalid, register rdata into iob_rdata, latch err=(rresp!=0), go to DONE.
- DONE: iob_ready=1 and iob_err=err for exactly one cycle, then go to IDLE. iob_valid is not sampled in DONE.
- iob_rdata holds its value until the next read completes. Writes leave it unchanged.
- Latency with zero-wait slave:
  - Write: capture + AW/W + B + DONE gives iob_ready on cycle 3 after iob_valid is sampled.
  - Read: capture + AR + R + DONE gives iob_ready on cycle 3.
- bready/rready are asserted only in their wait states. Early bvalid/rvalid is not possible under AXI ordering; no handling is required.
- Low address bits [1:0] are discarded.

Decomposition:
- Shared package constants: AXI_BURST_INCR=2'b01, AXI_SIZE_4B=3'd2, AXI_RESP_OKAY=2'b00, AXI_CACHE_DEFAULT=4'b0011, plus the FSM state encoding (3 bits).
- No sub-module; a single FSM with a capture register.

Test Plan:
- Write addr 0x000104, wdata 0xDEADBEEF, wstrb 0xF, zero-wait axi_ram → awaddr 0x000104, wdata/wstrb passed through, iob_ready 3 cycles later, iob_err 0.
- Read back 0x000104 → araddr 0x000104, iob_rdata 0xDEADBEEF with iob_ready, held after iob_valid drops.
- Write with wready at cycle 1 and awready delayed 4 cycles → wvalid drops after cycle 1, awvalid held 4 cycles, exactly one W beat, single iob_ready.
- Read with arready stalled 3 cycles and rresp=2'b10 (SLVERR) → arvalid stable throughout, iob_ready and iob_err pulse together for 1 cycle.
- Address 0x000107 with wstrb 0x2 → awaddr 0x000104, wstrb 0x2.
- rst asserted while in WRESP → awvalid/wvalid/bready/iob_ready low immediately. After release, a fresh read completes normally.
